// File: rtl/vend_order_controller.sv
// Customer front end of the vending machine: debounces switches and buttons,
// accumulates credit, runs the dispenser req/ack/done handshake and returns change.
module vend_order_controller #(
  parameter int DEBOUNCE_CYCLES = 1250000,
  parameter int PRICE_CENTS     = 100,
  parameter int MAX_CREDIT      = 995,
  parameter int ACK_TIMEOUT     = 250000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] Selection,
  input  logic       coin_quarter,
  input  logic       coin_dollar,
  input  logic       cancel,
  output logic       vend_req,
  output logic [2:0] vend_item,
  input  logic       vend_ack,
  input  logic       vend_done,
  output logic [9:0] credit_cents,
  output logic       change_valid,
  output logic [9:0] change_cents,
  output logic       coin_reject,
  output logic       insufficient,
  output logic       fault
);

  // state       | meaning
  // ST_IDLE     | no credit, waiting for the first coin
  // ST_CREDIT   | credit held, accepting coins, cancel and selections
  // ST_REQUEST  | vend_req raised, waiting for vend_ack or timeout
  // ST_DISPENSE | dispenser busy, waiting for vend_done
  // ST_SETTLE   | one cycle to return any remaining credit as change
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CREDIT,
    ST_REQUEST,
    ST_DISPENSE,
    ST_SETTLE
  } state_t;

  localparam int NIN = 11;
  localparam int DW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW  = $clog2(ACK_TIMEOUT + 1);
  localparam logic [DW-1:0] DEB_LOAD   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(ACK_TIMEOUT - 1);
  localparam logic [10:0]   MAX_C      = 11'(MAX_CREDIT);
  localparam logic [10:0]   QUARTER    = 11'd25;
  localparam logic [10:0]   DOLLAR     = 11'd100;
  localparam logic [9:0]    PRICE      = 10'(PRICE_CENTS);

  logic [NIN-1:0] raw;
  logic [NIN-1:0] sync_q1;
  logic [NIN-1:0] sync_q2;
  logic [NIN-1:0] deb;
  logic [NIN-1:0] deb_d;
  logic [DW-1:0]  deb_cnt [NIN];

  assign raw = {cancel, coin_dollar, coin_quarter, Selection};

  // Each counter reloads while the synchronized level matches the accepted
  // level, so any bounce back restarts the stability window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
      deb     <= '0;
      deb_d   <= '0;
      for (int i = 0; i < NIN; i++) deb_cnt[i] <= DEB_LOAD;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
      deb_d   <= deb;
      for (int i = 0; i < NIN; i++) begin
        if (sync_q2[i] == deb[i]) begin
          deb_cnt[i] <= DEB_LOAD;
        end else if (deb_cnt[i] == '0) begin
          deb[i]     <= sync_q2[i];
          deb_cnt[i] <= DEB_LOAD;
        end else begin
          deb_cnt[i] <= deb_cnt[i] - DW'(1);
        end
      end
    end
  end

  logic       quarter_ev;
  logic       dollar_ev;
  logic       cancel_ev;
  logic       sel_ev;
  logic [2:0] sel_idx;

  assign quarter_ev = deb[8] & ~deb_d[8];
  assign dollar_ev  = deb[9] & ~deb_d[9];
  assign cancel_ev  = deb[10] & ~deb_d[10];
  assign sel_ev     = (deb[7:0] != deb_d[7:0]) && $onehot(deb[7:0]);

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (deb[i]) sel_idx = 3'(i);
    end
  end

  // Dollar is applied first, then the quarter against the updated sum.
  logic [10:0] sum_base;
  logic [10:0] sum_dollar;
  logic [10:0] sum_coins;
  logic        dollar_ok;
  logic        quarter_ok;
  logic        coin_refused;

  always_comb begin
    sum_base     = {1'b0, credit_cents};
    dollar_ok    = (sum_base + DOLLAR) <= MAX_C;
    sum_dollar   = (dollar_ev && dollar_ok) ? sum_base + DOLLAR : sum_base;
    quarter_ok   = (sum_dollar + QUARTER) <= MAX_C;
    sum_coins    = (quarter_ev && quarter_ok) ? sum_dollar + QUARTER : sum_dollar;
    coin_refused = (dollar_ev && !dollar_ok) || (quarter_ev && !quarter_ok);
  end

  state_t        state_q;
  state_t        state_nxt;
  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_nxt;
  logic [9:0]    credit_nxt;
  logic [9:0]    change_nxt;
  logic [2:0]    item_nxt;
  logic          change_valid_nxt;
  logic          reject_nxt;
  logic          insuff_nxt;
  logic          fault_nxt;

  always_comb begin
    state_nxt        = state_q;
    timer_nxt        = timer_q;
    credit_nxt       = credit_cents;
    change_nxt       = change_cents;
    item_nxt         = vend_item;
    change_valid_nxt = 1'b0;
    reject_nxt       = 1'b0;
    insuff_nxt       = 1'b0;
    fault_nxt        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        credit_nxt = 10'(sum_coins);
        reject_nxt = coin_refused;
        if (sel_ev) insuff_nxt = 1'b1;
        if (dollar_ev || quarter_ev) state_nxt = ST_CREDIT;
      end
      ST_CREDIT: begin
        credit_nxt = 10'(sum_coins);
        reject_nxt = coin_refused;
        if (cancel_ev) begin
          change_nxt       = 10'(sum_coins);
          change_valid_nxt = 1'b1;
          credit_nxt       = '0;
          state_nxt        = ST_IDLE;
        end else if (sel_ev) begin
          if (sum_coins >= {1'b0, PRICE}) begin
            item_nxt  = sel_idx;
            timer_nxt = TIMER_LOAD;
            state_nxt = ST_REQUEST;
          end else begin
            insuff_nxt = 1'b1;
          end
        end
      end
      ST_REQUEST: begin
        reject_nxt = dollar_ev || quarter_ev;
        if (vend_ack) begin
          state_nxt = ST_DISPENSE;
        end else if (timer_q == '0) begin
          fault_nxt = 1'b1;
          state_nxt = ST_CREDIT;
        end else begin
          timer_nxt = timer_q - TW'(1);
        end
      end
      ST_DISPENSE: begin
        reject_nxt = dollar_ev || quarter_ev;
        if (vend_done) begin
          credit_nxt = credit_cents - PRICE;
          state_nxt  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        reject_nxt = dollar_ev || quarter_ev;
        if (credit_cents != '0) begin
          change_nxt       = credit_cents;
          change_valid_nxt = 1'b1;
        end
        credit_nxt = '0;
        state_nxt  = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      credit_cents <= '0;
      change_cents <= '0;
      vend_item    <= '0;
      change_valid <= 1'b0;
      coin_reject  <= 1'b0;
      insufficient <= 1'b0;
      fault        <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      timer_q      <= timer_nxt;
      credit_cents <= credit_nxt;
      change_cents <= change_nxt;
      vend_item    <= item_nxt;
      change_valid <= change_valid_nxt;
      coin_reject  <= reject_nxt;
      insufficient <= insuff_nxt;
      fault        <= fault_nxt;
    end
  end

  // Derived from the state register so an async reset drops it immediately.
  assign vend_req = (state_q == ST_REQUEST);

endmodule

// File: tb/tb_vend_order_controller.sv
// Testbench for vend_order_controller: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_vend_order_controller;

  localparam int DEB   = 4;
  localparam int TOUT  = 20;
  localparam int PRICE = 100;
  localparam int MAXC  = 995;

  localparam int PH_IDLE = 0, PH_CREDIT = 1, PH_REQ = 2, PH_DISP = 3, PH_SETTLE = 4;

  logic       clk;
  logic       reset_n;
  logic [7:0] Selection;
  logic       coin_quarter, coin_dollar, cancel;
  logic       vend_ack, vend_done;
  logic       vend_req;
  logic [2:0] vend_item;
  logic [9:0] credit_cents, change_cents;
  logic       change_valid, coin_reject, insufficient, fault;

  vend_order_controller #(
    .DEBOUNCE_CYCLES(DEB),
    .PRICE_CENTS(PRICE),
    .MAX_CREDIT(MAXC),
    .ACK_TIMEOUT(TOUT)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .Selection(Selection),
    .coin_quarter(coin_quarter),
    .coin_dollar(coin_dollar),
    .cancel(cancel),
    .vend_req(vend_req),
    .vend_item(vend_item),
    .vend_ack(vend_ack),
    .vend_done(vend_done),
    .credit_cents(credit_cents),
    .change_valid(change_valid),
    .change_cents(change_cents),
    .coin_reject(coin_reject),
    .insufficient(insufficient),
    .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  logic [10:0] raw_v;
  assign raw_v = {cancel, coin_dollar, coin_quarter, Selection};

  logic [10:0] m_s1, m_s2, m_deb, m_last;
  int          m_run [11];
  logic [2:0]  m_rise;
  bit          m_sel_ev;
  int          m_sel_idx;
  int          m_phase, m_credit, m_change, m_item, m_wait;
  bit          m_cv, m_rj, m_ins, m_flt;

  always @(posedge clk or negedge reset_n) begin : model
    int sum;
    bit dol, qtr, can;
    logic [10:0] nd;
    if (!reset_n) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0; m_last = '0;
      for (int i = 0; i < 11; i++) m_run[i] = 0;
      m_rise = '0; m_sel_ev = 0; m_sel_idx = 0;
      m_phase = PH_IDLE; m_credit = 0; m_change = 0; m_item = 0; m_wait = 0;
      m_cv = 0; m_rj = 0; m_ins = 0; m_flt = 0;
    end else begin
      qtr = m_rise[0]; dol = m_rise[1]; can = m_rise[2];
      m_cv = 0; m_rj = 0; m_ins = 0; m_flt = 0;
      if (m_phase == PH_IDLE || m_phase == PH_CREDIT) begin
        sum = m_credit;
        if (dol) begin if (sum + 100 <= MAXC) sum += 100; else m_rj = 1; end
        if (qtr) begin if (sum + 25 <= MAXC) sum += 25; else m_rj = 1; end
        if (m_phase == PH_IDLE) begin
          if (m_sel_ev) m_ins = 1;
          if (dol || qtr) m_phase = PH_CREDIT;
        end else if (can) begin
          m_change = sum; m_cv = 1; sum = 0; m_phase = PH_IDLE;
        end else if (m_sel_ev) begin
          if (sum >= PRICE) begin m_item = m_sel_idx; m_phase = PH_REQ; m_wait = 0; end
          else m_ins = 1;
        end
        m_credit = sum;
      end else begin
        if (dol || qtr) m_rj = 1;
        if (m_phase == PH_REQ) begin
          if (vend_ack) m_phase = PH_DISP;
          else begin
            m_wait++;
            if (m_wait == TOUT) begin m_flt = 1; m_phase = PH_CREDIT; end
          end
        end else if (m_phase == PH_DISP) begin
          if (vend_done) begin m_credit -= PRICE; m_phase = PH_SETTLE; end
        end else begin
          if (m_credit > 0) begin m_change = m_credit; m_cv = 1; end
          m_credit = 0; m_phase = PH_IDLE;
        end
      end
      // a level is accepted once it has been seen DEB samples in a row
      nd = m_deb;
      for (int i = 0; i < 11; i++) begin
        if (m_s2[i] == m_last[i]) m_run[i]++; else m_run[i] = 1;
        m_last[i] = m_s2[i];
        if (m_s2[i] != m_deb[i] && m_run[i] >= DEB) nd[i] = m_s2[i];
      end
      m_rise   = nd[10:8] & ~m_deb[10:8];
      m_sel_ev = (nd[7:0] != m_deb[7:0]) && ($countones(nd[7:0]) == 1);
      for (int i = 0; i < 8; i++) if (nd[i]) m_sel_idx = i;
      m_deb = nd;
      m_s2  = m_s1;
      m_s1  = raw_v;
    end
  end

  // ---------------- compare + event monitor ----------------
  int   n_req = 0, n_change = 0, n_rej = 0, n_ins = 0, n_fault = 0;
  int   last_item = 0, last_change = 0;
  logic req_prev = 1'b0;

  always @(negedge clk) begin
    check("credit", credit_cents, m_credit);
    check("change_valid", change_valid, m_cv);
    check("change_cents", change_cents, m_change);
    check("coin_reject", coin_reject, m_rj);
    check("insufficient", insufficient, m_ins);
    check("fault", fault, m_flt);
    check("vend_req", vend_req, (m_phase == PH_REQ) ? 1 : 0);
    if (m_phase == PH_REQ) check("vend_item", vend_item, m_item);
    if (vend_req && !req_prev) begin n_req++; last_item = vend_item; end
    req_prev = vend_req;
    if (change_valid) begin n_change++; last_change = change_cents; end
    if (coin_reject) n_rej++;
    if (insufficient) n_ins++;
    if (fault) n_fault++;
  end

  // ---------------- dispenser responder ----------------
  int ack_delay  = 0;
  int done_delay = 0;
  bit rand_disp  = 0;

  initial begin
    int d;
    vend_ack = 0; vend_done = 0;
    forever begin
      @(negedge clk);
      if (vend_req) begin
        d = rand_disp ? int'($urandom_range(0, 24)) : ack_delay;
        if (d < 0) begin
          for (int k = 0; k < 100 && vend_req; k++) @(negedge clk);
        end else begin
          repeat (d) @(negedge clk);
          vend_ack = 1; @(negedge clk); vend_ack = 0;
          repeat (rand_disp ? int'($urandom_range(0, 8)) : done_delay) @(negedge clk);
          vend_done = 1; @(negedge clk); vend_done = 0;
        end
      end else if (rand_disp && $urandom_range(0, 99) < 3) begin
        if ($urandom_range(0, 1) == 1) vend_done = 1; else vend_ack = 1;
        @(negedge clk);
        vend_done = 0; vend_ack = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic press_quarter();
    coin_quarter = 1; step(6); coin_quarter = 0; step(8);
  endtask
  task automatic press_dollar();
    coin_dollar = 1; step(6); coin_dollar = 0; step(8);
  endtask
  task automatic press_cancel();
    cancel = 1; step(6); cancel = 0; step(8);
  endtask
  task automatic select_item(input logic [7:0] v);
    Selection = v; step(10); Selection = 8'h00; step(10);
  endtask

  int b_req, b_chg, b_rej, b_ins, b_flt;
  int hold [3];
  int sel_hold;
  bit lvl;

  initial begin
    reset_n = 0; Selection = 8'h00; coin_quarter = 0; coin_dollar = 1; cancel = 1;
    step(3);
    check("rst_credit", credit_cents, 0);
    check("rst_req", vend_req, 0);
    check("rst_item", vend_item, 0);
    check("rst_change", change_cents, 0);
    check("rst_strobes", {change_valid, coin_reject, insufficient, fault}, 0);
    coin_dollar = 0; cancel = 0; step(2);
    reset_n = 1; step(4);

    // bounce 1-0-1 with 3-cycle spacing then a solid hold: one increment
    coin_dollar = 1; step(3); coin_dollar = 0; step(3);
    coin_dollar = 1; step(6); coin_dollar = 0; step(10);
    check("bounce_credit", credit_cents, 100);

    // reset mid-activity drops credit immediately
    coin_quarter = 1; Selection = 8'h10; step(3);
    #1 reset_n = 0; #1;
    check("midrst_credit", credit_cents, 0);
    check("midrst_req", vend_req, 0);
    step(2); coin_quarter = 0; Selection = 8'h00; step(2);
    reset_n = 1; step(4);

    // exact payment
    press_dollar();
    ack_delay = 3; done_delay = 2;
    b_req = n_req; b_chg = n_change;
    select_item(8'b00000100); step(10);
    check("exact_req", n_req - b_req, 1);
    check("exact_item", last_item, 2);
    check("exact_credit", credit_cents, 0);
    check("exact_nochange", n_change - b_chg, 0);

    // overpay with five quarters
    repeat (5) press_quarter();
    check("overpay_credit", credit_cents, 125);
    b_chg = n_change;
    select_item(8'b10000000); step(10);
    check("overpay_item", last_item, 7);
    check("overpay_chg_cnt", n_change - b_chg, 1);
    check("overpay_change", last_change, 25);
    check("overpay_credit0", credit_cents, 0);

    // insufficient credit, then a multi-bit selection
    repeat (3) press_quarter();
    b_ins = n_ins; b_req = n_req;
    select_item(8'b00000001); step(4);
    check("insuff_pulse", n_ins - b_ins, 1);
    check("insuff_credit", credit_cents, 75);
    b_ins = n_ins;
    select_item(8'b00000011); step(4);
    check("multi_noins", n_ins - b_ins, 0);
    check("multi_noreq", n_req - b_req, 0);

    // saturation at the credit ceiling
    repeat (9) press_dollar();
    check("sat_credit", credit_cents, 975);
    b_rej = n_rej;
    press_quarter();
    check("sat_reject", n_rej - b_rej, 1);
    check("sat_credit_kept", credit_cents, 975);
    press_cancel();
    check("sat_refund", last_change, 975);
    check("sat_credit0", credit_cents, 0);

    // coin and cancel while dispensing
    press_dollar();
    ack_delay = 0; done_delay = 40;
    b_rej = n_rej; b_chg = n_change;
    Selection = 8'h02; step(10); Selection = 8'h00; step(4);
    coin_quarter = 1; cancel = 1; step(6); coin_quarter = 0; cancel = 0; step(8);
    check("busy_reject", n_rej - b_rej, 1);
    step(40);
    check("busy_credit", credit_cents, 0);
    check("busy_nochange", n_change - b_chg, 0);

    // ack timeout keeps credit, then cancel refunds it
    ack_delay = -1;
    press_dollar(); press_quarter(); press_quarter();
    b_flt = n_fault; b_chg = n_change;
    select_item(8'b01000000); step(15);
    check("tout_fault", n_fault - b_flt, 1);
    check("tout_req", vend_req, 0);
    check("tout_credit", credit_cents, 150);
    press_cancel();
    check("tout_chg_cnt", n_change - b_chg, 1);
    check("tout_refund", last_change, 150);
    check("tout_credit0", credit_cents, 0);

    // randomized traffic
    rand_disp = 1;
    for (int b = 0; b < 3; b++) hold[b] = 0;
    sel_hold = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      step(1);
      if (cyc == 2000) begin #1 reset_n = 0; end
      if (cyc == 2003) reset_n = 1;
      for (int b = 0; b < 3; b++) begin
        if (hold[b] == 0) begin
          lvl = ($urandom_range(0, 99) < (b == 0 ? 30 : (b == 1 ? 15 : 8)));
          hold[b] = $urandom_range(1, 9);
          if (b == 0) coin_quarter = lvl;
          else if (b == 1) coin_dollar = lvl;
          else cancel = lvl;
        end else hold[b]--;
      end
      if (sel_hold == 0) begin
        case ($urandom_range(0, 9))
          0, 1, 2:    Selection = 8'h00;
          3, 4, 5, 6: Selection = 8'b1 << $urandom_range(0, 7);
          default:    Selection = 8'($urandom_range(0, 255));
        endcase
        sel_hold = $urandom_range(2, 14);
      end else sel_hold--;
    end

    Selection = 8'h00; coin_quarter = 0; coin_dollar = 0; cancel = 0;
    step(60);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/vend_order_controller.md
Name: vend_order_controller

Overview:
Customer-side front end for the vending machine. Debounces the selection switches, coin buttons and cancel button, and accumulates credit in cents. When a paid selection is made, it issues a vend request to the dispenser over a req/ack/done handshake, then returns change. Credit is exported for the 7-segment display multiplexer.

Parameters:
DEBOUNCE_CYCLES, 1250000, clk cycles an input must be stable before its new level is accepted (10 ms at 125 MHz)
PRICE_CENTS, 100, price of every item in cents
MAX_CREDIT, 995, credit ceiling in cents
ACK_TIMEOUT, 250000000, clk cycles to wait for vend_ack before aborting

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
Selection  in  8  raw item switches, one-hot intended
coin_quarter  in  1  raw button, +25 cents
coin_dollar  in  1  raw button, +100 cents
cancel  in  1  raw button, refund request
vend_req  out  1  request to dispenser, level
vend_item  out  3  index of requested item, valid while vend_req=1
vend_ack  in  1  dispenser accepted request
vend_done  in  1  dispenser finished, 1-cycle pulse
credit_cents  out  10  current credit, binary
change_valid  out  1  1-cycle pulse, change_cents valid
change_cents  out  10  amount returned
coin_reject  out  1  1-cycle pulse, coin refused
insufficient  out  1  1-cycle pulse, selection made with credit < PRICE_CENTS
fault  out  1  1-cycle pulse, ack timeout

Behaviour:
- Reset (async assert, sync deassert use): state IDLE; credit_cents, change_cents, vend_item and all strobes/levels = 0; debouncers take the level 0; counters cleared. Assertion mid-transaction drops vend_req immediately and loses the credit.
- Input conditioning:
  - Each raw input has a 2-flop synchronizer and a per-input stability counter.
  - The debounced level changes after DEBOUNCE_CYCLES consecutive cycles at the new synchronized level. Any bounce restarts the count.
  - A button event is a 1-cycle pulse on the debounced rising edge.
- Selection event: the debounced Selection vector changes to a value with exactly one bit set. vend_item = index of that bit. Zero or multi-bit values are ignored.
- Coin event:
  - Adds 25 or 100 if credit + value <= MAX_CREDIT; otherwise coin_reject pulses and credit is unchanged.
  - Simultaneous quarter and dollar events in the same cycle are both evaluated in order dollar then quarter, each against the updated sum.
- States:
  - IDLE: credit=0. A coin event moves to CREDIT. A selection event pulses insufficient. Cancel is ignored.
  - CREDIT:
    - Coin events accumulate.
    - Cancel (priority over selection in the same cycle): change_cents=credit, change_valid pulses, credit=0, go IDLE.
    - Selection with credit >= PRICE_CENTS: latch vend_item, go REQUEST.
    - Selection with credit < PRICE_CENTS: insufficient pulses, stay.
  - REQUEST:
    - vend_req=1 and vend_item held stable.
    - Sampling vend_ack=1 goes to DISPENSE, vend_req drops the next cycle.
    - ACK_TIMEOUT cycles without ack: vend_req=0, fault pulses, return to CREDIT with credit intact.
  - DISPENSE: wait for vend_done. On vend_done: credit -= PRICE_CENTS, go SETTLE.
  - SETTLE (1 cycle): if credit > 0, change_cents=credit, change_valid pulses, credit=0. Go IDLE.
- In REQUEST, DISPENSE and SETTLE: coin events pulse coin_reject; cancel and selection events are ignored (not queued).
- vend_done outside DISPENSE is ignored. vend_ack outside REQUEST is ignored.
- change_cents holds its last value until the next change_valid.
- credit_cents is registered and updates the cycle after the event.

Test Plan:
(Bench uses DEBOUNCE_CYCLES=4, ACK_TIMEOUT=20.)
- Reset and debounce: assert reset_n=0 during activity -> all outputs 0. coin_dollar bouncing 1-0-1 with 3-cycle spacing, then held 6 cycles -> exactly one credit increment to 100.
- Exact payment: dollar, then Selection=8'b00000100 -> vend_req=1 with vend_item=2; ack after 3 cycles -> vend_req=0; vend_done -> credit 0, no change_valid.
- Overpay: 5 quarters + Selection=8'b10000000 -> vend_item=7; after done, change_valid pulse with change_cents=25, credit 0.
- Insufficient and invalid selection: credit 75 + one-hot selection -> insufficient pulse, stays CREDIT. Selection=8'b00000011 -> no event.
- Saturation and busy rejection: credit 975 + quarter -> coin_reject, credit 975. During DISPENSE, a quarter -> coin_reject and cancel ignored.
- Timeout and cancel: request with no ack for 20 cycles -> fault pulse, vend_req=0, credit 150 kept; then cancel -> change_cents=150, credit 0, state IDLE.
